// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for a single-ported data memory: the CPU MEM stage and a loader/DMA port
// share one access slot, granted round-robin on ties; each access takes MEM_LAT cycles.
module data_mem_arbiter #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned ADDR_LENGTH = 8,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_LENGTH-1:0] cpu_addr,
  input  logic [WORD_LENGTH-1:0] cpu_wdata,
  output logic [WORD_LENGTH-1:0] cpu_rdata,
  output logic                   cpu_done,
  output logic                   cpu_stall,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [ADDR_LENGTH-1:0] dma_addr,
  input  logic [WORD_LENGTH-1:0] dma_wdata,
  output logic [WORD_LENGTH-1:0] dma_rdata,
  output logic                   dma_done,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  // MEM_LAT is limited to 1..8, so the remaining-cycle count fits in 3 bits.
  localparam logic [2:0] CntLoad = 3'(MEM_LAT - 1);

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   last_grant_q, last_grant_d;  // 1 = DMA
  logic                   owner_q, owner_d;            // 1 = DMA
  logic                   we_q, we_d;
  logic [ADDR_LENGTH-1:0] addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_LENGTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                   grant_dma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // DMA wins only when the CPU is absent or the CPU held the previous grant.
  assign grant_dma = dma_req & (~cpu_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          owner_d      = grant_dma;
          last_grant_d = grant_dma;
          we_d         = grant_dma ? dma_we    : cpu_we;
          addr_d       = grant_dma ? dma_addr  : cpu_addr;
          wdata_d      = grant_dma ? dma_wdata : cpu_wdata;
          cnt_d        = CntLoad;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == 3'd0) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_read  = (state_q == StAccess) & ~we_q;
  assign mem_write = (state_q == StAccess) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign cpu_done  = (state_q == StDone) & ~owner_q;
  assign dma_done  = (state_q == StDone) & owner_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboarded bench for data_mem_arbiter: directed CPU/DMA transactions against a small memory
// model, plus two extra instances that measure completion latency at MEM_LAT=1 and MEM_LAT=8.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_done;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       mem_read, mem_write, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];

  // Latency-only instances share one request line and see a constant memory.
  logic       l_req;
  logic       z1 = 1'b0;
  logic [7:0] z8 = 8'h00;
  logic       l1_done, l1_stall, l1_ddone, l1_rd, l1_wr, l1_busy;
  logic [7:0] l1_crd, l1_drd, l1_addr, l1_wd;
  logic       l8_done, l8_stall, l8_ddone, l8_rd, l8_wr, l8_busy;
  logic [7:0] l8_crd, l8_drd, l8_addr, l8_wd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       owner;  // 1 = DMA
    logic       is_read;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  data_mem_arbiter #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(l_req), .cpu_we(z1), .cpu_addr(z8), .cpu_wdata(z8),
    .cpu_rdata(l1_crd), .cpu_done(l1_done), .cpu_stall(l1_stall),
    .dma_req(z1), .dma_we(z1), .dma_addr(z8), .dma_wdata(z8),
    .dma_rdata(l1_drd), .dma_done(l1_ddone),
    .mem_read(l1_rd), .mem_write(l1_wr), .mem_addr(l1_addr), .mem_wdata(l1_wd),
    .mem_rdata(z8), .busy(l1_busy)
  );

  data_mem_arbiter #(.WORD_LENGTH(8), .ADDR_LENGTH(8), .MEM_LAT(8)) u_lat8 (
    .clk(clk), .rst(rst),
    .cpu_req(l_req), .cpu_we(z1), .cpu_addr(z8), .cpu_wdata(z8),
    .cpu_rdata(l8_crd), .cpu_done(l8_done), .cpu_stall(l8_stall),
    .dma_req(z1), .dma_we(z1), .dma_addr(z8), .dma_wdata(z8),
    .dma_rdata(l8_drd), .dma_done(l8_ddone),
    .mem_read(l8_rd), .mem_write(l8_wr), .mem_addr(l8_addr), .mem_wdata(l8_wd),
    .mem_rdata(z8), .busy(l8_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (cpu_done || dma_done)) begin
      exp_t e;
      chk("done_overlap", 32'(cpu_done & dma_done), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'({cpu_done, dma_done}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_owner", 32'(dma_done), 32'(e.owner));
        if (e.is_read) chk("sb_rdata", 32'(e.owner ? dma_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input bit hold);
    int n = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    do begin @(negedge clk); n++; end while (!cpu_done && n < 40);
    if (!cpu_done) chk("cpu_timeout", 32'(cpu_done), 32'd1);
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input bit hold);
    int n = 0;
    dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    do begin @(negedge clk); n++; end while (!dma_done && n < 40);
    if (!dma_done) chk("dma_timeout", 32'(dma_done), 32'd1);
    @(posedge clk); #1;
    if (!hold) dma_req = 1'b0;
  endtask

  initial begin
    int nr, stall_bad, done_at, acc, pulses, d1, d8;
    rst = 1'b1; l_req = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    #12;
    chk("rst_busy", 32'(busy), 0);           chk("rst_cpu_done", 32'(cpu_done), 0);
    chk("rst_dma_done", 32'(dma_done), 0);   chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0); chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0); chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    chk("rst_dma_rdata", 32'(dma_rdata), 0); chk("rst_cpu_stall", 32'(cpu_stall), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests out of reset: CPU write first, then DMA reads it back.
    sb.push_back('{1'b0, 1'b0, 8'h00});
    sb.push_back('{1'b1, 1'b1, 8'h3C});
    fork
      cpu_op(1'b1, 8'h20, 8'h3C, 1'b0);
      dma_op(1'b0, 8'h20, 8'h00, 1'b0);
    join

    // CPU read timing: request cycle is cycle 1, done expected in cycle MEM_LAT+2.
    sb.push_back('{1'b0, 1'b1, 8'hA5});
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    nr = 0; stall_bad = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_read) nr++;
      if (cpu_done) begin
        done_at = c;
        chk("stall_in_done", 32'(cpu_stall), 0);
        break;
      end else if (cpu_stall !== 1'b1) stall_bad++;
    end
    chk("rd_done_cycle", 32'(done_at), 32'd4);
    chk("rd_mem_read_cycles", 32'(nr), 32'd2);
    chk("rd_stall_before_done", 32'(stall_bad), 0);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    @(posedge clk); #1 cpu_req = 0;

    // DMA write with CPU and DMA inputs disturbed mid-access.
    sb.push_back('{1'b1, 1'b0, 8'h00});
    dma_we = 1; dma_addr = 8'h05; dma_wdata = 8'h77; dma_req = 1;
    acc = 0; pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write) begin
        acc++;
        chk("dma_wr_addr", 32'(mem_addr), 32'h05);
        chk("dma_wr_data", 32'(mem_wdata), 32'h77);
        if (acc == 1) begin cpu_addr = 8'h99; dma_addr = 8'h66; dma_wdata = 8'h11; end
      end
      if (dma_done) begin pulses++; dma_req = 0; end
    end
    chk("dma_wr_cycles", 32'(acc), 32'd2);
    chk("dma_done_pulses", 32'(pulses), 32'd1);
    chk("dma_wr_mem", 32'(mem[8'h05]), 32'h77);
    @(posedge clk); #1;

    // Both held for four accesses: last grant was DMA, so CPU, DMA, CPU, DMA.
    sb.push_back('{1'b0, 1'b1, 8'hA5});
    sb.push_back('{1'b1, 1'b1, 8'h3C});
    sb.push_back('{1'b0, 1'b1, 8'h77});
    sb.push_back('{1'b1, 1'b1, 8'h6A});
    fork
      begin cpu_op(1'b0, 8'h10, 8'h00, 1'b1); cpu_op(1'b0, 8'h05, 8'h00, 1'b0); end
      begin dma_op(1'b0, 8'h20, 8'h00, 1'b1); dma_op(1'b0, 8'h30, 8'h00, 1'b0); end
    join

    // Reset in the first ACCESS cycle of a CPU write: access discarded, no done.
    cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'hEE; cpu_req = 1;
    @(posedge clk); #2;
    chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_mem_write", 32'(mem_write), 0);
    chk("rst_mid_mem_read", 32'(mem_read), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    cpu_req = 0;
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_mem_unchanged", 32'(mem[8'h40]), 32'h1A);

    // First grant on the first edge with a request after reset release.
    @(posedge clk); #1;
    sb.push_back('{1'b0, 1'b1, 8'h1A});
    cpu_we = 0; cpu_addr = 8'h40; cpu_req = 1;
    @(posedge clk); #1;
    chk("first_grant_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 20 && !cpu_done; c++) @(negedge clk);
    chk("post_rst_done", 32'(cpu_done), 32'd1);
    @(posedge clk); #1 cpu_req = 0;

    // Latency at MEM_LAT=1 and MEM_LAT=8.
    l_req = 1; d1 = 0; d8 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (l1_done && d1 == 0) d1 = c;
      if (l8_done && d8 == 0) d8 = c;
    end
    l_req = 0;
    chk("lat1_done_cycle", 32'(d1), 32'd3);
    chk("lat8_done_cycle", 32'(d8), 32'd10);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
